// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared owner/tag types and image constants for the ROM fetch arbiter
package rom_arb_pkg;

  localparam int IMG_W     = 400;
  localparam int IMG_H     = 300;
  localparam int ROM_DEPTH = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   oor;
  } tag_t;

  localparam tag_t TAG_NONE = '{owner: OWN_NONE, oor: 1'b0};

endpackage

// File: rtl/rom_tag_pipe.sv
// rtl/rom_tag_pipe.sv - fixed-depth delay line carrying the owner/oor tag of each ROM slot
module rom_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t head_o
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_fetch_arbiter.sv
// rtl/rom_fetch_arbiter.sv - single-port image ROM shared by display (priority) and one aux requester
// Optional statistics counters: ROM_ARB_STATS_EN
module rom_fetch_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 4,
  parameter int ROM_DEPTH = rom_arb_pkg::ROM_DEPTH,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              aux_req_valid,
  output logic              aux_req_ready,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_rsp_valid,
  input  logic              aux_rsp_ready,
  output logic [DATA_W-1:0] aux_rsp_data,
  output logic              aux_rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [15:0]       aux_grant_cnt,
  output logic [15:0]       aux_stall_cnt
`endif
);

  import rom_arb_pkg::*;

  logic              credit_q, credit_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              aux_grant;
  logic              sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  tag_t              issue_tag, head_tag;
  logic              head_disp, head_aux;
  logic [DATA_W-1:0] head_data;

  assign aux_req_ready = !disp_req && credit_q;
  assign aux_grant     = aux_req_valid && aux_req_ready;
  assign sel_addr      = disp_req ? disp_addr : aux_addr;
  assign sel_oor       = 32'(sel_addr) >= 32'(ROM_DEPTH);

  // Out-of-range slots still travel the pipe so the owner sees a zeroed reply.
  always_comb begin
    issue_tag  = TAG_NONE;
    rom_addr_d = rom_addr_q;
    if (disp_req || aux_grant) begin
      issue_tag.owner = disp_req ? OWN_DISP : OWN_AUX;
      issue_tag.oor   = sel_oor;
      if (!sel_oor) rom_addr_d = sel_addr;
    end
  end

  rom_tag_pipe #(
    .DEPTH (1 + ROM_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_i  (issue_tag),
    .head_o (head_tag)
  );

  assign head_disp = head_tag.owner == OWN_DISP;
  assign head_aux  = head_tag.owner == OWN_AUX;
  assign head_data = head_tag.oor ? '0 : rom_data;

  assign disp_valid = head_disp;
  assign disp_data  = head_disp ? head_data : '0;

  // The head cycle presents ROM data directly; the register only holds it under backpressure.
  assign aux_rsp_valid = rsp_valid_q || head_aux;
  assign aux_rsp_data  = rsp_valid_q ? rsp_data_q : (head_aux ? head_data : '0);
  assign aux_rsp_err   = rsp_valid_q ? rsp_err_q : (head_aux && head_tag.oor);

  always_comb begin
    credit_d = credit_q;
    if (aux_grant) credit_d = 1'b0;
    if (aux_rsp_valid && aux_rsp_ready) credit_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q    <= 1'b1;
      rom_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      rom_addr_q <= rom_addr_d;
      if (head_aux && !aux_rsp_ready) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= head_data;
        rsp_err_q   <= head_tag.oor;
      end else if (rsp_valid_q && aux_rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rom_addr = rom_addr_q;

`ifdef ROM_ARB_STATS_EN
  logic [15:0] grant_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (aux_grant && grant_cnt_q != 16'hFFFF) grant_cnt_q <= grant_cnt_q + 16'd1;
      if (aux_req_valid && !aux_req_ready && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign aux_grant_cnt = grant_cnt_q;
  assign aux_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/rom_fetch_arbiter.md
# rom_fetch_arbiter

Shares the single-port image ROM (400×300 pixels, 4-bit palette index, 120000 words) between the display pixel fetch path and one auxiliary requester, e.g. an overlay loader or a ROM scrubber. It sits between the display module and the image ROM in the pixel clock domain. Display fetches have absolute priority and a fixed latency, so video timing never slips. The auxiliary port gets ROM slots only in cycles the display leaves idle, such as blanking, and uses a valid/ready handshake.

## Interface
- ADDR_W, 17, ROM address width
- DATA_W, 4, ROM data width
- ROM_DEPTH, 120000, number of valid ROM words; addresses ≥ ROM_DEPTH are out of range
- ROM_LAT, 1, ROM read latency in cycles from rom_addr sampled to rom_data valid (1..3)
- clk  in  1  pixel clock (40 MHz domain); all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display fetch request this cycle
- disp_addr  in  ADDR_W  display fetch address
- disp_valid  out  1  display data valid strobe
- disp_data  out  DATA_W  display read data
- aux_req_valid  in  1  auxiliary request valid
- aux_req_ready  out  1  auxiliary request accepted when valid && ready
- aux_addr  in  ADDR_W  auxiliary read address
- aux_rsp_valid  out  1  auxiliary response held until accepted
- aux_rsp_ready  in  1  auxiliary consumer ready
- aux_rsp_data  out  DATA_W  auxiliary read data
- aux_rsp_err  out  1  auxiliary address was out of range
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM read data

## Operation
- Issue slot per cycle. The grant is decided combinationally from the inputs and registered into rom_addr and the tag pipeline.
- disp_req=1: the display wins unconditionally. aux_req_ready=0 in that cycle.
- disp_req=0, aux_req_valid=1 and credit=1: aux is granted and credit is cleared.
- No grant: rom_addr holds its value and a NONE tag is issued.
- Tag pipeline: 1+ROM_LAT stages of {owner: NONE/DISP/AUX, oor}. oor = addr ≥ ROM_DEPTH.
- For an oor request, rom_addr is not updated, and the returned data is forced to 0.
- Tag FSM per stage: NONE, DISP and AUX. Only the head stage acts.
  - DISP head: disp_valid=1, disp_data = oor ? 0 : rom_data.
  - AUX head: load the response register, set aux_rsp_valid, aux_rsp_err=oor.
- Credit: a single aux transaction is outstanding, either in flight or buffered. Credit returns in the cycle aux_rsp_valid && aux_rsp_ready.
- aux_req_ready = !disp_req && credit. It does not depend on aux_req_valid.
- Simultaneous credit return and new aux request in the same cycle: the request is not granted. Credit becomes visible the next cycle.
- Reset mid-operation clears all in-flight tags. No response is produced for pre-reset requests.

## Timing
- Display latency is exactly 1+ROM_LAT cycles from disp_req high to disp_valid. With ROM_LAT=1 that is 2 cycles, and it never varies.
- Back-to-back disp_req gives one disp_valid per cycle.
- Aux latency is 1+ROM_LAT cycles from handshake to aux_rsp_valid, when the grant is immediate.
- Aux throughput is at most one per 2+ROM_LAT cycles.
- aux_rsp_valid stays high and aux_rsp_data/err stay stable until aux_rsp_ready.
- Reset values:
  - disp_valid=0, disp_data=0
  - aux_rsp_valid=0, aux_rsp_data=0, aux_rsp_err=0
  - rom_addr=0
  - credit=1 (so aux_req_ready=!disp_req after reset)
  - all tags NONE

## Configuration
- ROM_ARB_STATS_EN defined: adds outputs aux_grant_cnt[15:0] and aux_stall_cnt[15:0].
  - aux_grant_cnt increments on each aux handshake.
  - aux_stall_cnt increments each cycle aux_req_valid=1 && aux_req_ready=0.
  - Both saturate at 16'hFFFF and reset to 0.
- ROM_ARB_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package rom_arb_pkg holds:
  - the owner enum (NONE/DISP/AUX)
  - the tag struct {owner, oor}
  - IMG_W=400, IMG_H=300 and ROM_DEPTH=120000 constants
- One natural sub-module, rom_tag_pipe: a parameterised tag delay line of depth 1+ROM_LAT with asynchronous reset to NONE.

## Test plan
- Reset with disp_req=1, addr=5 held. After release, disp_valid first rises 2 cycles later, with disp_data equal to ROM[5].
- Display stream: addr 0..399, continuous. disp_valid is high for 400 consecutive cycles, data matches the ROM model, and aux_req_ready=0 throughout.
- Aux contention: aux_req_valid=1, addr=1000, for 10 cycles of disp_req=1. No handshake occurs. The grant happens in the first idle cycle, and the response is ROM[1000] 2 cycles later.
- Aux backpressure: aux_rsp_ready=0 for 20 cycles. aux_rsp_valid stays stable and aux_req_ready stays 0. On ready, credit returns and the next request is granted the following cycle.
- Out of range: aux_addr=120000 gives aux_rsp_err=1 and data 0. disp_addr=131071 gives disp_data=0, and rom_addr is unchanged in both cases.
- Reset asserted with an aux transaction in flight: no aux_rsp_valid after release and credit=1. With ROM_ARB_STATS_EN, the counters read 0.
